// File: rtl/spi_adapter_pkg.sv
// spi_adapter_pkg
//   Shared width helpers and types for the multi-channel SPI minion adapter.
//   - calc_chan_bits / calc_pw : derive channel-id and payload widths from
//     the packet width and channel count.
//   - wrt_flag_pos / rd_flag_pos : positions of the write/read flag bits in
//     the full SPI packet.
//   - spi_msg_t : {chan, payload} layout for the default 34-bit, 4-channel
//     configuration.
package spi_adapter_pkg;

  function automatic int calc_chan_bits(input int num_chans);
    return $clog2(num_chans);
  endfunction

  function automatic int calc_pw(input int nbits, input int num_chans);
    return nbits - 2 - $clog2(num_chans);
  endfunction

  function automatic int wrt_flag_pos(input int nbits);
    return nbits - 1;
  endfunction

  function automatic int rd_flag_pos(input int nbits);
    return nbits - 2;
  endfunction

  localparam int def_nbits     = 34;
  localparam int def_num_chans = 4;
  localparam int def_chan_bits = calc_chan_bits(def_num_chans);
  localparam int def_pw        = calc_pw(def_nbits, def_num_chans);

  typedef struct packed {
    logic [def_chan_bits-1:0] chan;
    logic [def_pw-1:0]        payload;
  } spi_msg_t;

endpackage

// File: rtl/spi_adapter_arbiter.sv
// spi_adapter_arbiter
//   Picks one requesting channel for the SPI pull path.
//   Build option SPI_ADAPTER_RR_ARB_EN:
//     defined   - round robin; search starts at ptr, and after a granted
//                 pull ptr moves to (grant+1) mod num_chans.
//     undefined - fixed priority, lowest index wins; no pointer register.
// Ports:
//   clk, reset, advance  (round-robin build only) pointer clock/reset and
//                        "a pull is being taken this cycle"
//   req                  per-channel request (cm queue non-empty)
//   grant_oh, grant_idx  one-hot and binary grant, zero when nothing requests
//   any_req              at least one request
module spi_adapter_arbiter #(
  parameter  int num_chans = 4,
  localparam int chan_bits = $clog2(num_chans)
) (
`ifdef SPI_ADAPTER_RR_ARB_EN
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance,
`endif
  input  logic [num_chans-1:0] req,
  output logic [num_chans-1:0] grant_oh,
  output logic [chan_bits-1:0] grant_idx,
  output logic                 any_req
);

  logic [chan_bits-1:0] start_ptr;

  // Offset from the start pointer, wrapped by num_chans rather than by
  // 2^chan_bits so non-power-of-two channel counts rotate correctly.
  function automatic logic [chan_bits-1:0] wrap_idx(input logic [chan_bits-1:0] base,
                                                    input int off);
    int s;
    s = int'(base) + off;
    if (s >= num_chans) s = s - num_chans;
    return chan_bits'(s);
  endfunction

`ifdef SPI_ADAPTER_RR_ARB_EN
  logic [chan_bits-1:0] ptr;

  assign start_ptr = ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && any_req) begin
      ptr <= (int'(grant_idx) == num_chans - 1) ? '0 : grant_idx + chan_bits'(1);
    end
  end
`else
  assign start_ptr = '0;
`endif

  assign any_req = |req;

  always_comb begin
    logic                 found;
    logic [chan_bits-1:0] idx;
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < num_chans; i++) begin
      idx = wrap_idx(start_ptr, i);
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_adapter_normal_queue.sv
// spi_adapter_normal_queue
//   Normal (non-bypass, non-pipe) val/rdy FIFO. enq_rdy depends only on
//   occupancy, so a full queue refuses an enqueue even when it is being
//   drained in the same cycle. Dequeued data is always read from storage,
//   so enqueued data is visible at the output one cycle later.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   enq_val/rdy/msg      enqueue side
//   deq_val/rdy/msg      dequeue side
//   count                current occupancy
module spi_adapter_normal_queue #(
  parameter  int w     = 30,
  parameter  int depth = 2,
  localparam int cw    = $clog2(depth + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_val,
  output logic          enq_rdy,
  input  logic [w-1:0]  enq_msg,
  output logic          deq_val,
  input  logic          deq_rdy,
  output logic [w-1:0]  deq_msg,
  output logic [cw-1:0] count
);

  localparam int aw = (depth > 1) ? $clog2(depth) : 1;

  logic [w-1:0]  mem [depth];
  logic [aw-1:0] head;
  logic [aw-1:0] tail;
  logic          enq_fire;
  logic          deq_fire;

  function automatic logic [aw-1:0] bump(input logic [aw-1:0] p);
    return (p == aw'(depth - 1)) ? '0 : p + aw'(1);
  endfunction

  assign enq_rdy  = (count != cw'(depth));
  assign deq_val  = (count != '0);
  assign deq_msg  = mem[head];
  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_val & deq_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= bump(tail);
      if (deq_fire) head <= bump(head);
      if (enq_fire && !deq_fire)      count <= count + cw'(1);
      else if (deq_fire && !enq_fire) count <= count - cw'(1);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[tail] <= enq_msg;
  end

endmodule

// File: rtl/spi_adapter_multichan.sv
// spi_adapter_multichan
//   SPI minion push/pull adapter fanning out to num_chans val/rdy channel
//   pairs. Writes are routed by channel id into per-channel mc queues;
//   responses from per-channel cm queues are arbitrated onto the pull path
//   and tagged with their channel id. drop_flag latches any lost write.
//   Build option SPI_ADAPTER_RR_ARB_EN selects round-robin response
//   arbitration; default is fixed priority (lowest channel first).
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   push_en, push_msg_val_wrt/rd    SPI push strobe and its write/read flags
//   push_msg_data                   {chan, payload}
//   pull_en                         SPI pull strobe
//   pull_msg_val/spc/data           pull result, write-space hint, {chan, payload}
//   recv_msg/val/rdy                component-to-master inputs (flattened)
//   send_msg/val/rdy                master-to-component outputs (flattened)
//   drop_flag                       sticky dropped-write indicator
module spi_adapter_multichan
  import spi_adapter_pkg::*;
#(
  parameter  int nbits       = 34,
  parameter  int num_entries = 2,
  parameter  int num_chans   = 4,
  localparam int chan_bits   = calc_chan_bits(num_chans),
  localparam int pw          = calc_pw(nbits, num_chans),
  localparam int cw          = $clog2(num_entries + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_en,
  input  logic                    push_msg_val_wrt,
  input  logic                    push_msg_val_rd,
  input  logic [nbits-3:0]        push_msg_data,
  input  logic                    pull_en,
  output logic                    pull_msg_val,
  output logic                    pull_msg_spc,
  output logic [nbits-3:0]        pull_msg_data,
  input  logic [num_chans*pw-1:0] recv_msg,
  input  logic [num_chans-1:0]    recv_val,
  output logic [num_chans-1:0]    recv_rdy,
  output logic [num_chans*pw-1:0] send_msg,
  output logic [num_chans-1:0]    send_val,
  input  logic [num_chans-1:0]    send_rdy,
  output logic                    drop_flag
);

  logic                    wr;
  logic                    rd;
  logic [chan_bits-1:0]    wr_chan;
  logic [pw-1:0]           wr_payload;
  logic [num_chans-1:0]    chan_hit;
  logic [num_chans-1:0]    mc_enq_val;
  logic [num_chans-1:0]    mc_enq_rdy;
  logic [num_chans-1:0]    cm_enq_rdy;
  logic [num_chans-1:0]    cm_deq_val;
  logic [num_chans-1:0]    cm_deq_rdy;
  logic [num_chans*pw-1:0] cm_deq_msg;
  logic [cw-1:0]           mc_count        [num_chans];
  logic [cw-1:0]           cm_count_unused [num_chans];
  logic [num_chans-1:0]    grant_oh;
  logic [chan_bits-1:0]    grant_idx;
  logic                    any_req;
  logic [pw-1:0]           grant_payload;

  assign wr         = push_en & push_msg_val_wrt;
  assign rd         = pull_en & push_msg_val_rd;
  assign wr_chan    = push_msg_data[nbits-3 -: chan_bits];
  assign wr_payload = push_msg_data[pw-1:0];

  // Decoding by equality against each real channel means an id at or above
  // num_chans simply hits nothing and falls through to the drop path.
  always_comb begin
    chan_hit = '0;
    for (int k = 0; k < num_chans; k++) begin
      chan_hit[k] = (wr_chan == chan_bits'(k));
    end
  end

  assign mc_enq_val = {num_chans{wr}} & chan_hit;

  // Space is promised only if every channel can still take the next write,
  // including the one already being written this cycle.
  always_comb begin
    pull_msg_spc = 1'b1;
    for (int k = 0; k < num_chans; k++) begin
      if (!mc_enq_rdy[k] ||
          (mc_enq_val[k] && !(int'(mc_count[k]) < num_entries - 1))) begin
        pull_msg_spc = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_flag <= 1'b0;
    end else if (wr && ((mc_enq_val & mc_enq_rdy) == '0)) begin
      drop_flag <= 1'b1;
    end
  end

  for (genvar k = 0; k < num_chans; k++) begin : g_chan
    spi_adapter_normal_queue #(
      .w     (pw),
      .depth (num_entries)
    ) u_mc_q (
      .clk     (clk),
      .reset   (reset),
      .enq_val (mc_enq_val[k]),
      .enq_rdy (mc_enq_rdy[k]),
      .enq_msg (wr_payload),
      .deq_val (send_val[k]),
      .deq_rdy (send_rdy[k]),
      .deq_msg (send_msg[k*pw +: pw]),
      .count   (mc_count[k])
    );

    spi_adapter_normal_queue #(
      .w     (pw),
      .depth (num_entries)
    ) u_cm_q (
      .clk     (clk),
      .reset   (reset),
      .enq_val (recv_val[k]),
      .enq_rdy (cm_enq_rdy[k]),
      .enq_msg (recv_msg[k*pw +: pw]),
      .deq_val (cm_deq_val[k]),
      .deq_rdy (cm_deq_rdy[k]),
      .deq_msg (cm_deq_msg[k*pw +: pw]),
      .count   (cm_count_unused[k])
    );
  end

  // Queues are empty under reset, so their ready would read 1; hold it low
  // until reset is released.
  assign recv_rdy = cm_enq_rdy & {num_chans{~reset}};

  spi_adapter_arbiter #(
    .num_chans (num_chans)
  ) u_arb (
`ifdef SPI_ADAPTER_RR_ARB_EN
    .clk       (clk),
    .reset     (reset),
    .advance   (rd),
`endif
    .req       (cm_deq_val),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign cm_deq_rdy = {num_chans{rd}} & grant_oh;

  always_comb begin
    grant_payload = '0;
    for (int k = 0; k < num_chans; k++) begin
      if (grant_oh[k]) grant_payload = grant_payload | cm_deq_msg[k*pw +: pw];
    end
  end

  assign pull_msg_val  = rd & any_req;
  assign pull_msg_data = pull_msg_val ? {grant_idx, grant_payload} : '0;

endmodule
